// File: rtl/mdu_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
// Optional madd/maddu decode is enabled by defining MDU_MADD_EN.
package mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8
    } md_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_mult_class(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) || (op == MD_MADDU);
`else
        return (op == MD_MULT) || (op == MD_MULTU);
`endif
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit result generation: {hi,lo} for mult, {rem,quot} for div.
// The accumulate path exists only when MDU_MADD_EN is defined.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] res,
    output logic        div_zero
);

    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               a_neg;
    logic               b_neg;
    logic        [31:0] a_mag;
    logic        [31:0] b_mag;
    logic        [31:0] q_mag;
    logic        [31:0] r_mag;
    logic        [31:0] quot;
    logic        [31:0] rem;

    assign a_sx   = $signed({{32{a[31]}}, a});
    assign b_sx   = $signed({{32{b[31]}}, b});
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed division on magnitudes keeps -2^31 / -1 well defined (wraps to 0x80000000).
    assign a_neg    = (op == MD_DIV) && a[31];
    assign b_neg    = (op == MD_DIV) && b[31];
    assign a_mag    = a_neg ? (32'd0 - a) : a;
    assign b_mag    = b_neg ? (32'd0 - b) : b;
    assign div_zero = (b == 32'd0);
    assign q_mag    = div_zero ? 32'd0 : (a_mag / b_mag);
    assign r_mag    = div_zero ? 32'd0 : (a_mag % b_mag);
    assign quot     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem      = a_neg ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        res = {hi, lo};
        case (op)
            MD_MULT:  res = prod_s;
            MD_MULTU: res = prod_u;
            MD_DIV,
            MD_DIVU:  res = {rem, quot};
`ifdef MDU_MADD_EN
            MD_MADD:  res = {hi, lo} + prod_s;
            MD_MADDU: res = {hi, lo} + prod_u;
`endif
            default:  res = {hi, lo};
        endcase
    end

endmodule

// File: rtl/mdu.sv
// E-stage multiply/divide unit: latency countdown, busy flag and HI/LO registers.
// Define MDU_MADD_EN to accept madd/maddu (accumulate into {hi,lo}).
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [31:0]        hi_d;
    logic [31:0]        lo_d;
    logic [63:0]        calc_res;
    logic               calc_dz;
    logic [63:0]        res_q;
    logic               dz_q;
    logic               accept;

    mdu_calc u_calc (
        .op       (md_op),
        .a        (a),
        .b        (b),
        .hi       (hi),
        .lo       (lo),
        .res      (calc_res),
        .div_zero (calc_dz)
    );

    assign accept = start && (state_q == S_IDLE) && (is_mult_class(md_op) || is_div(md_op));
    assign busy   = (state_q == S_RUN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi;
        lo_d    = lo;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_RUN;
                    cnt_d   = is_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end else if (!start && md_op == MD_MTHI) begin
                    hi_d = a;
                end else if (!start && md_op == MD_MTLO) begin
                    lo_d = a;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 1'b1;
                // Final countdown edge publishes the result; a zero divisor leaves HI/LO alone.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    if (!dz_q) begin
                        hi_d = res_q[63:32];
                        lo_d = res_q[31:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi      <= hi_d;
            lo      <= lo_d;
        end
    end

    // Result held from acceptance until the countdown expires; reset discards it via the FSM.
    always_ff @(posedge clk) begin
        if (accept) begin
            res_q <= calc_res;
            dz_q  <= is_div(md_op) && calc_dz;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases plus random ops against a reference model.
// Expectations track MDU_MADD_EN the same way the design does.
module tb_mdu;
    import mdu_pkg::*;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_chk;
    int          n_fail;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Architectural effect of one op on the model HI/LO, plus its busy duration.
    task automatic model_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                            output int lat);
        longint      sx;
        longint      sy;
        logic [63:0] ux;
        logic [63:0] uy;
        logic [63:0] p;
        logic [63:0] q64;
        logic [63:0] r64;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = {32'd0, x};
        uy  = {32'd0, y};
        lat = 0;
        case (op)
            MD_MULT:  begin p = sx * sy; {m_hi, m_lo} = p; lat = MULT_LAT; end
            MD_MULTU: begin p = ux * uy; {m_hi, m_lo} = p; lat = MULT_LAT; end
            MD_DIV: begin
                lat = DIV_LAT;
                if (y != 0) begin
                    q64 = sx / sy;
                    r64 = sx % sy;
                    m_lo = q64[31:0];
                    m_hi = r64[31:0];
                end
            end
            MD_DIVU: begin
                lat = DIV_LAT;
                if (y != 0) begin
                    m_lo = x / y;
                    m_hi = x % y;
                end
            end
`ifdef MDU_MADD_EN
            MD_MADD:  begin p = sx * sy; {m_hi, m_lo} = {m_hi, m_lo} + p; lat = MULT_LAT; end
            MD_MADDU: begin p = ux * uy; {m_hi, m_lo} = {m_hi, m_lo} + p; lat = MULT_LAT; end
`endif
            MD_MTHI:  m_hi = x;
            MD_MTLO:  m_lo = x;
            default:  ;
        endcase
    endtask

    // Called right after a falling edge; returns right after the falling edge where busy is low.
    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input bit poke, input string tag);
        int          lat;
        int          n;
        logic [31:0] h0;
        logic [31:0] l0;
        h0 = m_hi;
        l0 = m_lo;
        model_op(op, x, y, lat);
        start = 1'b1;
        md_op = op;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        md_op = MD_NONE;
        a     = $urandom;
        b     = $urandom;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            chk({tag, "_hold"}, {hi, lo}, {h0, l0});
            if (poke && n == 2) begin
                start = 1'b1; md_op = MD_MULT; a = $urandom; b = $urandom;
            end else if (poke && n == 3) begin
                start = 1'b0; md_op = MD_MTHI; a = 32'hDEADBEEF;
            end else begin
                start = 1'b0; md_op = MD_NONE;
            end
            @(negedge clk);
        end
        start = 1'b0;
        md_op = MD_NONE;
        chk({tag, "_busy_cycles"}, 64'(n), 64'(lat));
        chk({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] x, input string tag);
        int lat;
        model_op(op, x, 32'd0, lat);
        start = 1'b0;
        md_op = op;
        a     = x;
        @(negedge clk);
        md_op = MD_NONE;
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
    endtask

    initial begin
        logic [31:0] specials [5];
        logic [31:0] x;
        logic [31:0] y;
        logic [3:0]  op;
        specials[0] = 32'h0000_0000;
        specials[1] = 32'h0000_0001;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'h7FFF_FFFF;
        n_chk  = 0;
        n_fail = 0;
        m_hi   = '0;
        m_lo   = '0;
        reset  = 1'b1;
        start  = 1'b0;
        md_op  = MD_NONE;
        a      = '0;
        b      = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, "mult_neg");
        chk("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, "multu");
        chk("multu_const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg");
        chk("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(MD_DIVU, 32'd7, 32'd0, 1'b0, "divu_zero");
        chk("divu_zero_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        mt(MD_MTHI, 32'h1234_5678, "mthi");
        chk("mthi_const", {32'd0, hi}, 64'h1234_5678);
        issue(MD_MULT, 32'd100, 32'd200, 1'b1, "poke");
        chk("poke_const", {hi, lo}, 64'd20000);
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        issue(MD_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, "div_negb");

        // Async reset in the third busy cycle of a divide.
        mt(MD_MTHI, 32'hA5A5_A5A5, "pre_rst");
        start = 1'b1; md_op = MD_DIV; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0; md_op = MD_NONE;
        repeat (2) @(negedge clk);
        chk("rst_pre_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_async_busy", {63'd0, busy}, 64'd0);
        chk("rst_async_hilo", {hi, lo}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("rst_no_result", {31'd0, busy, hi, lo[31:1]}, 64'd0);
        end

        mt(MD_MTHI, 32'd0, "madd_sethi");
        mt(MD_MTLO, 32'hFFFF_FFFF, "madd_setlo");
        issue(MD_MADDU, 32'd1, 32'd1, 1'b0, "maddu");
`ifdef MDU_MADD_EN
        chk("maddu_const", {hi, lo}, 64'h0000_0001_0000_0000);
`else
        chk("maddu_const", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
`endif

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 8));
            x  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            y  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            if (op == MD_MTHI || op == MD_MTLO)
                mt(op, x, "rnd_mt");
            else
                issue(op, x, y, ($urandom_range(0, 3) == 0), "rnd_op");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
